// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } arb_state_t;

endpackage

// File: rtl/grant_watchdog.sv
// Grant-duration watchdog: counts stalled grant cycles and flags when the
// current cycle is the last one the arbiter is allowed to wait for ACCESS.
module grant_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  // Clear while no grant is active, advance on each stalled grant cycle.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data access.
// Data wins by default; a streak counter forces a fetch after MAX_DSTREAK data
// completions while a fetch waits, and a watchdog aborts grants that hang.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      halt,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      mem_err
);

  localparam int SW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t   state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic         halted_q, halted_d;

  logic wdog_clr, wdog_en, wdog_expired;
  logic dreq, force_fetch, granted, ram_done;

  assign dreq        = dREN | dWEN;
  assign force_fetch = iREN && !halted_q && (streak_q == STREAK_MAX);
  assign granted     = (state_q != IDLE);
  assign ram_done    = (ramstate == ACCESS) || (ramstate == ERROR);
  assign wdog_clr    = !granted;
  assign wdog_en     = granted && !ram_done;

  assign iload = ramload;
  assign dload = ramload;

  grant_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (CLK),
    .rst     (RST),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // Next-state, streak/halt bookkeeping and the RAM/requester drives for the current state.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    halted_d = halted_q | halt;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    mem_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dreq && !force_fetch) begin
          state_d = DGRANT;
        end else if (iREN && !halted_q) begin
          state_d = IGRANT;
        end
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          state_d = IDLE;
          if (iREN && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (ramstate == ERROR) begin
          mem_err = 1'b1;
          state_d = IDLE;
        end else if (!dreq) begin
          state_d = IDLE;
        end else if (wdog_expired) begin
          mem_err = 1'b1;
          state_d = IDLE;
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (ramstate == ACCESS) begin
          iwait    = 1'b0;
          state_d  = IDLE;
          streak_d = '0;
        end else if (ramstate == ERROR) begin
          mem_err = 1'b1;
          state_d = IDLE;
        end else if (!iREN) begin
          state_d = IDLE;
        end else if (wdog_expired) begin
          mem_err = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (!iREN) begin
      streak_d = '0;
    end
  end

  // Arbiter state, data streak and sticky halt registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      halted_q <= halted_d;
    end
  end

endmodule
